signal_generator_multi: RTL and testbench

//  Multi-waveform DAC sample generator with gain, offset, saturation and a soft-start amplitude ramp.

---
 rtl/signal_gen_pkg.sv | 50 +++++
 rtl/amp_ramp_fsm.sv | 98 +++++++++
 rtl/signal_generator_multi.sv | 161 ++++++++++++++++
 tb/tb_signal_generator_multi.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/signal_gen_pkg.sv
// Shared types and constants for the multi-waveform DAC sample generator.
// Holds waveform codes, ramp FSM encoding, cfg_data field positions and the
// output saturation helper used by the final datapath stage.
package signal_gen_pkg;

  typedef enum logic [2:0] {
    SIG_SINE     = 3'd0,
    SIG_SQUARE   = 3'd1,
    SIG_TRIANGLE = 3'd2,
    SIG_SAW      = 3'd3,
    SIG_DC       = 3'd4
  } sig_type_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } ramp_state_e;

  // cfg_data layout
  localparam int CFG_TYPE_LSB = 0;
  localparam int CFG_TYPE_W   = 3;
  localparam int CFG_INV_BIT  = 3;
  localparam int CFG_OFF_LSB  = 16;
  localparam int CFG_AMP_LSB  = 32;
  localparam int CFG_AMP_W    = 16;
  localparam int CFG_STEP_LSB = 48;
  localparam int CFG_STEP_W   = 16;

  // Amplitude is unsigned Q1.15: 0x8000 is unity gain.
  localparam int AMP_FRAC = 15;

  // Clamp a signed value to the n-bit two's complement range; result is
  // returned sign-correct in the low n bits of a 16-bit word.
  function automatic logic [15:0] saturate(input logic signed [31:0] x, input int n);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (n - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (n - 1));
    if (x > hi) begin
      saturate = hi[15:0];
    end else if (x < lo) begin
      saturate = lo[15:0];
    end else begin
      saturate = x[15:0];
    end
  endfunction

endpackage

// File: rtl/amp_ramp_fsm.sv
// Soft-start amplitude ramp: walks amp_eff toward the configured amplitude or zero.
// Latency: amp_eff/state update one clock after a qualifying sample (in_v_i).
// Backpressure: none; holds all state on cycles without in_v_i.
module amp_ramp_fsm
  import signal_gen_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_v_i,
  input  logic        enable_i,
  input  logic [15:0] amp_i,
  input  logic [15:0] step_i,
  output logic [15:0] amp_eff_o,
  output logic [1:0]  state_o
);

  ramp_state_e state_q, state_d;
  logic [15:0] amp_q, amp_d;
  logic [16:0] sum_up;
  logic        step_zero;

  // 17-bit sum so an up-step near full scale cannot wrap past the target.
  assign sum_up    = {1'b0, amp_q} + {1'b0, step_i};
  assign step_zero = (step_i == 16'd0);

  // State and amplitude registers, advancing only with the sample stream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      amp_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      amp_q   <= amp_d;
    end
  end

  // Next state: direction changes keep the current amplitude; a zero step
  // means "no ramp" and jumps straight to the end point.
  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    if (in_v_i) begin
      case (state_q)
        ST_IDLE: begin
          amp_d = 16'd0;
          if (enable_i) begin
            if (step_zero) begin
              amp_d   = amp_i;
              state_d = ST_RUN;
            end else begin
              state_d = ST_RAMP_UP;
            end
          end
        end
        ST_RAMP_UP: begin
          if (!enable_i) begin
            state_d = ST_RAMP_DOWN;
          end else if (step_zero || (sum_up >= {1'b0, amp_i})) begin
            // Also catches amp_q already above a lowered target.
            amp_d   = amp_i;
            state_d = ST_RUN;
          end else begin
            amp_d = sum_up[15:0];
          end
        end
        ST_RUN: begin
          amp_d = amp_i;
          if (!enable_i) begin
            if (step_zero) begin
              amp_d   = 16'd0;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RAMP_DOWN;
            end
          end
        end
        ST_RAMP_DOWN: begin
          if (enable_i) begin
            state_d = ST_RAMP_UP;
          end else if (step_zero || (amp_q <= step_i)) begin
            amp_d   = 16'd0;
            state_d = ST_IDLE;
          end else begin
            amp_d = amp_q - step_i;
          end
        end
        default: begin
          amp_d   = 16'd0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign amp_eff_o = amp_q;
  assign state_o   = state_q;

endmodule

// File: rtl/signal_generator_multi.sv
// Multi-waveform DAC sample generator with gain, invert, offset, saturation and soft-start ramp.
// Latency: 3 qualifying samples from DDS input to m_axis_tdata/m_axis_tvalid.
// Backpressure: none; every register holds on cycles where sine or phase is not valid.
module signal_generator_multi
  import signal_gen_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH       = 16,
  parameter int AXIS_TDATA_PHASE_WIDTH = 16,
  parameter int AXIS_TDATA_OUT_WIDTH   = 32,
  parameter int DAC_WIDTH              = 14,
  parameter int CFG_DATA_WIDTH         = 64
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                              s_axis_tvalid,
  input  logic [AXIS_TDATA_PHASE_WIDTH-1:0] s_axis_tdata_phase,
  input  logic                              s_axis_tvalid_phase,
  input  logic [CFG_DATA_WIDTH-1:0]         cfg_data,
  input  logic                              enable,
  output logic [AXIS_TDATA_OUT_WIDTH-1:0]   m_axis_tdata,
  output logic                              m_axis_tvalid,
  output logic [1:0]                        ramp_state
);

  localparam int N  = DAC_WIDTH;
  localparam int TW = AXIS_TDATA_WIDTH;
  localparam int PW = AXIS_TDATA_PHASE_WIDTH;
  localparam int MW = N + 18;  // product width: (N+1)-bit signed x 17-bit signed

  localparam logic [N-1:0] MSB_ONLY = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] FS_POS   = ~MSB_ONLY;
  localparam logic [N-1:0] FS_NEG   = MSB_ONLY | {{(N-1){1'b0}}, 1'b1};

  logic in_v;
  assign in_v = s_axis_tvalid & s_axis_tvalid_phase;

  // Configuration fields, taken along with each sample.
  logic [CFG_TYPE_W-1:0] cfg_type;
  logic                  cfg_inv;
  logic [N-1:0]          cfg_off;
  logic [15:0]           cfg_amp;
  logic [15:0]           cfg_step;
  assign cfg_type = cfg_data[CFG_TYPE_LSB +: CFG_TYPE_W];
  assign cfg_inv  = cfg_data[CFG_INV_BIT];
  assign cfg_off  = cfg_data[CFG_OFF_LSB +: N];
  assign cfg_amp  = cfg_data[CFG_AMP_LSB +: CFG_AMP_W];
  assign cfg_step = cfg_data[CFG_STEP_LSB +: CFG_STEP_W];

  logic [15:0] amp_eff;

  amp_ramp_fsm u_ramp (
    .clk_i     (clk),
    .rst_ni    (aresetn),
    .in_v_i    (in_v),
    .enable_i  (enable),
    .amp_i     (cfg_amp),
    .step_i    (cfg_step),
    .amp_eff_o (amp_eff),
    .state_o   (ramp_state)
  );

  // Stage 1 inputs: top N phase bits drive the synthetic shapes.
  logic [N-1:0]           q;
  logic [N-1:0]           q_dbl;
  logic [N-1:0]           tri_u;
  logic signed [TW-1:0]   sine_sh;
  logic [N-1:0]           wave_d;
  assign q       = s_axis_tdata_phase[PW-1 -: N];
  assign q_dbl   = {q[N-2:0], 1'b0};
  assign tri_u   = q[N-1] ? ~q_dbl : q_dbl;
  assign sine_sh = $signed(s_axis_tdata) >>> (TW - N);

  // Waveform select; offset-binary shapes are flipped to signed by toggling the MSB.
  always_comb begin
    wave_d = '0;
    case (cfg_type)
      SIG_SINE:     wave_d = sine_sh[N-1:0];
      SIG_SQUARE:   wave_d = q[N-1] ? FS_NEG : FS_POS;
      SIG_TRIANGLE: wave_d = tri_u ^ MSB_ONLY;
      SIG_SAW:      wave_d = q ^ MSB_ONLY;
      SIG_DC:       wave_d = FS_POS;
      default:      wave_d = '0;
    endcase
  end

  // Pipeline registers
  logic [N-1:0]        w1_q;
  logic                inv1_q;
  logic [N-1:0]        off1_q;
  logic                v1_q;
  logic signed [N+2:0] p2_q;
  logic [N-1:0]        off2_q;
  logic                v2_q;
  logic [N-1:0]        out_q;
  logic                v3_q;

  // Stage 2: optional negation (one extra bit so -(-2^(N-1)) fits), then gain.
  logic signed [N:0]    w_ext;
  logic signed [N:0]    w_inv;
  logic signed [MW-1:0] w_x;
  logic signed [MW-1:0] amp_x;
  logic signed [MW-1:0] prod;
  logic signed [MW-1:0] prod_sh;
  logic signed [N+2:0]  p2_d;
  assign w_ext   = $signed({w1_q[N-1], w1_q});
  assign w_inv   = inv1_q ? -w_ext : w_ext;
  assign w_x     = MW'(w_inv);
  assign amp_x   = MW'($signed({1'b0, amp_eff}));
  assign prod    = w_x * amp_x;
  assign prod_sh = prod >>> AMP_FRAC;  // arithmetic shift = floor
  assign p2_d    = prod_sh[N+2:0];

  // Stage 3: add the static bias, clamp to the DAC range.
  logic signed [N+3:0] sum3;
  logic [15:0]         sat16;
  logic [N-1:0]        out_d;
  assign sum3  = $signed({p2_q[N+2], p2_q}) + $signed({{4{off2_q[N-1]}}, off2_q});
  assign sat16 = saturate(32'(sum3), N);
  assign out_d = sat16[N-1:0];

  // Three-stage datapath; valid bits travel with the data so tvalid holds on stalls.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      w1_q   <= '0;
      inv1_q <= 1'b0;
      off1_q <= '0;
      v1_q   <= 1'b0;
      p2_q   <= '0;
      off2_q <= '0;
      v2_q   <= 1'b0;
      out_q  <= '0;
      v3_q   <= 1'b0;
    end else if (in_v) begin
      w1_q   <= wave_d;
      inv1_q <= cfg_inv;
      off1_q <= cfg_off;
      v1_q   <= 1'b1;
      p2_q   <= p2_d;
      off2_q <= off1_q;
      v2_q   <= v1_q;
      out_q  <= out_d;
      v3_q   <= v2_q;
    end
  end

  logic signed [15:0] out16;
  assign out16         = 16'($signed(out_q));
  assign m_axis_tdata  = {{(AXIS_TDATA_OUT_WIDTH-16){1'b0}}, out16};
  assign m_axis_tvalid = v3_q;

  // Bits that are reserved in cfg_data or dropped by the fixed-point scaling.
  logic unused_ok;
  assign unused_ok = ^{cfg_data[CFG_OFF_LSB-1:CFG_INV_BIT+1],
                       cfg_data[CFG_AMP_LSB-1:CFG_OFF_LSB+N],
                       s_axis_tdata_phase[PW-N-1:0],
                       sine_sh[TW-1:N],
                       prod_sh[MW-1:N+3],
                       sat16[15:N]};

endmodule

// File: tb/tb_signal_generator_multi.sv
// Self-checking bench for signal_generator_multi (N = 14).
// Directed vector table, multi-cycle ramp/hold/reset sequences, then random traffic
// compared every cycle against an integer reference model of the sample stream.
module tb_signal_generator_multi;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic [15:0] s_axis_tdata_phase;
  logic        s_axis_tvalid_phase;
  logic [63:0] cfg_data;
  logic        enable;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic [1:0]  ramp_state;

  always #5 clk = ~clk;

  signal_generator_multi dut (
    .clk                 (clk),
    .aresetn             (aresetn),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tdata_phase  (s_axis_tdata_phase),
    .s_axis_tvalid_phase (s_axis_tvalid_phase),
    .cfg_data            (cfg_data),
    .enable              (enable),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tvalid       (m_axis_tvalid),
    .ramp_state          (ramp_state)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Current configuration as plain integers
  int c_typ, c_inv, c_off, c_amp, c_step;

  // Reference model: one entry per pipeline position, plus ramp amplitude/state
  int m_w1, m_inv1, m_off1, m_v1;
  int m_p, m_off2, m_v2;
  int m_out, m_v3;
  int m_amp, m_st;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  task automatic set_cfg(input int typ, input int inv, input int off, input int amp, input int step);
    c_typ = typ; c_inv = inv; c_off = off; c_amp = amp; c_step = step;
    cfg_data = {step[15:0], amp[15:0], 2'b00, off[13:0], 12'h000, inv[0], typ[2:0]};
  endtask

  function automatic int wave(input int typ, input int ph, input int sn);
    int q;
    q = ph / 4;
    case (typ)
      0: return sn >>> 2;
      1: return (q >= 8192) ? -8191 : 8191;
      2: return ((q < 8192) ? 2 * q : 16383 - (2 * q - 16384)) - 8192;
      3: return q - 8192;
      4: return 8191;
      default: return 0;
    endcase
  endfunction

  function automatic int sat(input int x);
    if (x > 8191) return 8191;
    if (x < -8192) return -8192;
    return x;
  endfunction

  task automatic model_reset();
    m_w1 = 0; m_inv1 = 0; m_off1 = 0; m_v1 = 0;
    m_p = 0; m_off2 = 0; m_v2 = 0;
    m_out = 0; m_v3 = 0;
    m_amp = 0; m_st = 0;
  endtask

  // One accepted sample: each stage takes the previous stage's value.
  task automatic model_step();
    longint prod;
    int en;
    en = int'(enable);
    m_out = sat(m_p + m_off2);
    m_v3  = m_v2;
    prod  = longint'(m_inv1 != 0 ? -m_w1 : m_w1) * longint'(m_amp);
    m_p   = int'(prod >>> 15);
    m_off2 = m_off1;
    m_v2   = m_v1;
    m_w1   = wave(c_typ, int'(s_axis_tdata_phase), int'($signed(s_axis_tdata)));
    m_inv1 = c_inv;
    m_off1 = c_off;
    m_v1   = 1;
    // Ramp rules (0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN)
    case (m_st)
      0: begin
        m_amp = 0;
        if (en != 0) begin
          if (c_step == 0) begin m_amp = c_amp; m_st = 2; end
          else m_st = 1;
        end
      end
      1: begin
        if (en == 0) m_st = 3;
        else if (c_step == 0 || m_amp + c_step >= c_amp) begin m_amp = c_amp; m_st = 2; end
        else m_amp = m_amp + c_step;
      end
      2: begin
        m_amp = c_amp;
        if (en == 0) begin
          if (c_step == 0) begin m_amp = 0; m_st = 0; end
          else m_st = 3;
        end
      end
      default: begin
        if (en != 0) m_st = 1;
        else if (c_step == 0 || m_amp - c_step <= 0) begin m_amp = 0; m_st = 0; end
        else m_amp = m_amp - c_step;
      end
    endcase
  endtask

  // Advance one clock and compare all outputs against the model
  task automatic step_cyc();
    @(posedge clk);
    if (aresetn && s_axis_tvalid && s_axis_tvalid_phase) model_step();
    #1;
    chk("tdata", m_axis_tdata, {16'h0000, 16'(m_out)});
    chk("tvalid", 32'(m_axis_tvalid), 32'(m_v3));
    chk("state", 32'(ramp_state), 32'(m_st));
  endtask

  task automatic wait_state(input int st, input int limit, output int n);
    n = 0;
    do begin
      step_cyc();
      n++;
    end while (int'(ramp_state) != st && n < limit);
  endtask

  typedef struct {
    int typ; int inv; int off; int amp; int ph; int sn;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int n;
    vecs[0]  = '{0, 0,     0, 'h8000, 'h0000, 'h4000, 32'h0000_1000};
    vecs[1]  = '{1, 0,     0, 'h4000, 'h0000, 'h0000, 32'h0000_0FFF};
    vecs[2]  = '{1, 0,     0, 'h4000, 'h8000, 'h0000, 32'h0000_F000};
    vecs[3]  = '{2, 0,     0, 'h8000, 'h0000, 'h0000, 32'h0000_E000};
    vecs[4]  = '{2, 0,     0, 'h8000, 'h4000, 'h0000, 32'h0000_0000};
    vecs[5]  = '{2, 0,     0, 'h8000, 'h8000, 'h0000, 32'h0000_1FFF};
    vecs[6]  = '{4, 0,  1000, 'hFFFF, 'h0000, 'h0000, 32'h0000_1FFF};
    vecs[7]  = '{1, 0, -1000, 'hFFFF, 'h8000, 'h0000, 32'h0000_E000};
    vecs[8]  = '{4, 0, -8192, 'h0000, 'h0000, 'h0000, 32'h0000_E000};
    vecs[9]  = '{0, 1,     0, 'h8000, 'h0000, 'h4000, 32'h0000_F000};
    vecs[10] = '{3, 0,     0, 'h8000, 'hC000, 'h0000, 32'h0000_1000};
    vecs[11] = '{5, 0,     5, 'h8000, 'h1234, 'h4000, 32'h0000_0005};
    vecs[12] = '{0, 0,     0, 'h8000, 'h0000, 'h8000, 32'h0000_E000};
    vecs[13] = '{4, 0,     0, 'h8000, 'h0000, 'h0000, 32'h0000_1FFF};

    aresetn = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    s_axis_tdata_phase = '0; s_axis_tvalid_phase = 1'b0;
    enable = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("reset_tdata", m_axis_tdata, 32'h0);
    chk("reset_tvalid", 32'(m_axis_tvalid), 32'h0);
    chk("reset_state", 32'(ramp_state), 32'h0);
    aresetn = 1'b1;

    // Directed steady-state vectors (no ramp, unity path latency flushed)
    s_axis_tvalid = 1'b1; s_axis_tvalid_phase = 1'b1; enable = 1'b1;
    for (int i = 0; i < 14; i++) begin
      set_cfg(vecs[i].typ, vecs[i].inv, vecs[i].off, vecs[i].amp, 0);
      s_axis_tdata_phase = vecs[i].ph[15:0];
      s_axis_tdata       = vecs[i].sn[15:0];
      repeat (4) step_cyc();
      chk($sformatf("vec%0d", i), m_axis_tdata, vecs[i].exp);
    end

    // Stall: dropping sine valid freezes the output and its valid
    set_cfg(2, 0, 0, 'h8000, 0);
    s_axis_tdata_phase = 16'h8000;
    repeat (4) step_cyc();
    s_axis_tvalid = 1'b0;
    s_axis_tdata_phase = 16'h0000;
    repeat (5) begin
      step_cyc();
      chk("hold_tdata", m_axis_tdata, 32'h0000_1FFF);
      chk("hold_tvalid", 32'(m_axis_tvalid), 32'h1);
    end
    s_axis_tvalid = 1'b1;
    repeat (4) step_cyc();
    chk("after_hold", m_axis_tdata, 32'h0000_E000);

    // Ramp: DC, unity target, step 0x1000
    set_cfg(4, 0, 0, 'h8000, 'h1000);
    enable = 1'b0;
    wait_state(0, 20, n);
    chk("to_idle", 32'(ramp_state), 32'h0);
    enable = 1'b1;
    wait_state(2, 30, n);
    chk("up_len", 32'(n), 32'd9);
    repeat (3) step_cyc();
    chk("run_dc", m_axis_tdata, 32'h0000_1FFF);
    enable = 1'b0;
    wait_state(0, 30, n);
    chk("down_len", 32'(n), 32'd9);
    repeat (3) step_cyc();
    chk("idle_dc", m_axis_tdata, 32'h0);

    // Reverse mid ramp-up at 0x3000
    enable = 1'b1;
    repeat (4) step_cyc();
    chk("mid_up", 32'(ramp_state), 32'd1);
    enable = 1'b0;
    wait_state(0, 30, n);
    chk("rev_down_len", 32'(n), 32'd4);

    // Reverse mid ramp-down at 0x6000
    enable = 1'b1;
    wait_state(2, 30, n);
    enable = 1'b0;
    repeat (3) step_cyc();
    chk("mid_down", 32'(ramp_state), 32'd3);
    enable = 1'b1;
    wait_state(2, 30, n);
    chk("rev_up_len", 32'(n), 32'd3);

    // Asynchronous reset during ramp-up
    enable = 1'b0;
    wait_state(0, 30, n);
    enable = 1'b1;
    repeat (3) step_cyc();
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_tdata", m_axis_tdata, 32'h0);
    chk("arst_tvalid", 32'(m_axis_tvalid), 32'h0);
    chk("arst_state", 32'(ramp_state), 32'h0);
    model_reset();
    repeat (2) step_cyc();
    aresetn = 1'b1;
    wait_state(2, 30, n);
    chk("restart_len", 32'(n), 32'd9);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) begin
        int a, s;
        case ($urandom_range(0, 3))
          0: a = 'hFFFF;
          1: a = 'h8000;
          default: a = int'($urandom_range(0, 65535));
        endcase
        case ($urandom_range(0, 3))
          0: s = 0;
          1: s = 'hFFFF;
          2: s = int'($urandom_range(1, 255));
          default: s = int'($urandom_range(1, 16383));
        endcase
        set_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 16383)) - 8192, a, s);
      end
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      s_axis_tvalid       = ($urandom_range(0, 9) != 0);
      s_axis_tvalid_phase = ($urandom_range(0, 19) != 0);
      s_axis_tdata_phase  = 16'($urandom);
      s_axis_tdata        = 16'($urandom);
      step_cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
